// File: rtl/msg_buf.sv
// Byte-wise message capture buffer with a 1-cycle, big-endian word read port.
// Bytes at or beyond the current byte count always read back as zero.
module msg_buf #(
  parameter int unsigned DEPTH_BYTES = 1024,
  parameter int unsigned WORD_BYTES  = 4,
  localparam int unsigned AW = $clog2(DEPTH_BYTES),
  localparam int unsigned RW = $clog2(DEPTH_BYTES / WORD_BYTES),
  localparam int unsigned CW = AW + 1,
  localparam int unsigned DW = 8 * WORD_BYTES
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [7:0]    in_data,
  input  logic          in_last,
  input  logic          rd_req,
  input  logic [RW-1:0] rd_addr,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  output logic [CW-1:0] byte_count,
  output logic          msg_done,
  output logic          blk_avail
);

  logic [7:0]    mem [DEPTH_BYTES];
  logic [AW-1:0] lane_addr [WORD_BYTES];
  logic [DW-1:0] rd_word;
  logic          wr_fire;

  // in_ready must drop the same cycle clear is raised, so it stays combinational.
  assign in_ready  = rst_n && !msg_done && (byte_count != CW'(DEPTH_BYTES)) && !clear;
  assign wr_fire   = in_valid && in_ready;
  assign blk_avail = (byte_count >= CW'(64));

  // Storage carries no reset; stale bytes are hidden by the byte_count mask.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[byte_count[AW-1:0]] <= in_data;
  end

  // Lane 0 is the MSB; lanes at or past byte_count are forced to zero.
  always_comb begin
    rd_word = '0;
    for (int k = 0; k < int'(WORD_BYTES); k++) begin
      lane_addr[k] = AW'(rd_addr) * AW'(WORD_BYTES) + AW'(k);
      if ({1'b0, lane_addr[k]} < byte_count)
        rd_word[8*(int'(WORD_BYTES)-1-k) +: 8] = mem[lane_addr[k]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_count <= '0;
      msg_done   <= 1'b0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
    end else if (clear) begin
      byte_count <= '0;
      msg_done   <= 1'b0;
      rd_valid   <= 1'b0;
    end else begin
      if (wr_fire) begin
        byte_count <= byte_count + CW'(1);
        if (in_last) msg_done <= 1'b1;
      end
      rd_valid <= rd_req;
      if (rd_req) rd_data <= rd_word;
    end
  end

endmodule

// File: tb/tb_msg_buf.sv
// Directed self-checking bench for msg_buf: default geometry plus an 8-byte-word instance.
module tb_msg_buf;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear, in_valid, in_last, rd_req;
  logic [7:0]  in_data, rd_addr;
  logic        in_ready, rd_valid, msg_done, blk_avail;
  logic [31:0] rd_data;
  logic [10:0] byte_count;

  logic        w_clear, w_in_valid, w_in_last, w_rd_req;
  logic [7:0]  w_in_data;
  logic [3:0]  w_rd_addr;
  logic        w_in_ready, w_rd_valid, w_msg_done, w_blk_avail;
  logic [63:0] w_rd_data;
  logic [7:0]  w_byte_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  msg_buf u_dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
    .byte_count(byte_count), .msg_done(msg_done), .blk_avail(blk_avail)
  );

  msg_buf #(.DEPTH_BYTES(128), .WORD_BYTES(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .clear(w_clear),
    .in_valid(w_in_valid), .in_ready(w_in_ready), .in_data(w_in_data), .in_last(w_in_last),
    .rd_req(w_rd_req), .rd_addr(w_rd_addr), .rd_valid(w_rd_valid), .rd_data(w_rd_data),
    .byte_count(w_byte_count), .msg_done(w_msg_done), .blk_avail(w_blk_avail)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] d, input logic l);
    in_valid = 1'b1; in_data = d; in_last = l;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a);
    rd_req = 1'b1; rd_addr = a;
    tick();
    rd_req = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (byte_count !== 11'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", byte_count); end
    checks++; if (msg_done !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", msg_done); end
    checks++; if (blk_avail !== 1'b0) begin errors++; $display("FAIL rst_blk got %b exp 0", blk_avail); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rst_rd_valid got %b exp 0", rd_valid); end
    checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL rst_rd_data got %h exp 0", rd_data); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b exp 0", in_ready); end
    #9 rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rel_in_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_abc(input string tag);
    wr(8'h61, 1'b0); wr(8'h62, 1'b0); wr(8'h63, 1'b1);
    rd(8'd0);
    checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL %s_rd_valid got %b exp 1", tag, rd_valid); end
    checks++; if (rd_data !== 32'h61626300) begin errors++; $display("FAIL %s_rd_data got %h exp 61626300", tag, rd_data); end
    checks++; if (byte_count !== 11'd3) begin errors++; $display("FAIL %s_count got %0d exp 3", tag, byte_count); end
    checks++; if (msg_done !== 1'b1) begin errors++; $display("FAIL %s_done got %b exp 1", tag, msg_done); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL %s_in_ready got %b exp 0", tag, in_ready); end
    wr(8'h64, 1'b0);
    checks++; if (byte_count !== 11'd3) begin errors++; $display("FAIL %s_post_done_count got %0d exp 3", tag, byte_count); end
  endtask

  task automatic test_block();
    logic [31:0] exp;
    do_clear();
    checks++; if (msg_done !== 1'b0 || byte_count !== 11'd0) begin errors++; $display("FAIL blk_clear got done=%b cnt=%0d exp 0/0", msg_done, byte_count); end
    for (int i = 0; i < 64; i++) begin
      if (i == 63) begin
        checks++; if (blk_avail !== 1'b0) begin errors++; $display("FAIL blk_avail_63 got %b exp 0", blk_avail); end
      end
      wr(8'(i), 1'b0);
    end
    checks++; if (blk_avail !== 1'b1) begin errors++; $display("FAIL blk_avail_64 got %b exp 1", blk_avail); end
    rd(8'd15);
    checks++; if (rd_data !== 32'h3C3D3E3F) begin errors++; $display("FAIL blk_rd15 got %h exp 3c3d3e3f", rd_data); end
    rd_req = 1'b1;
    for (int a = 0; a < 16; a++) begin
      rd_addr = 8'(a);
      tick();
      exp = {8'(4*a), 8'(4*a+1), 8'(4*a+2), 8'(4*a+3)};
      checks++; if (rd_valid !== 1'b1 || rd_data !== exp) begin errors++; $display("FAIL b2b_%0d got v=%b %h exp v=1 %h", a, rd_valid, rd_data, exp); end
    end
    rd_req = 1'b0;
    tick();
    checks++; if (rd_valid !== 1'b0 || rd_data !== 32'h3C3D3E3F) begin errors++; $display("FAIL idle_hold got v=%b %h exp v=0 3c3d3e3f", rd_valid, rd_data); end
    // Read word 16 while byte 64 is being written in the same cycle.
    in_valid = 1'b1; in_data = 8'hAA; rd_req = 1'b1; rd_addr = 8'd16;
    tick();
    in_valid = 1'b0; rd_req = 1'b0;
    checks++; if (rd_valid !== 1'b1 || rd_data !== 32'h0) begin errors++; $display("FAIL rw_same got v=%b %h exp v=1 0", rd_valid, rd_data); end
    checks++; if (byte_count !== 11'd65) begin errors++; $display("FAIL rw_count got %0d exp 65", byte_count); end
    rd(8'd16);
    checks++; if (rd_data !== 32'hAA000000) begin errors++; $display("FAIL rw_after got %h exp aa000000", rd_data); end
  endtask

  task automatic test_full();
    do_clear();
    in_valid = 1'b1; in_last = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      in_data = 8'(i);
      if (i == 1023) begin
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_ready_1023 got %b exp 1", in_ready); end
      end
      tick();
    end
    in_data = 8'hEE; in_last = 1'b1;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    checks++; if (byte_count !== 11'd1024) begin errors++; $display("FAIL full_count got %0d exp 1024", byte_count); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b exp 0", in_ready); end
    checks++; if (msg_done !== 1'b0) begin errors++; $display("FAIL full_done got %b exp 0", msg_done); end
    rd(8'd255);
    checks++; if (rd_data !== 32'hFCFDFEFF) begin errors++; $display("FAIL full_rd255 got %h exp fcfdfeff", rd_data); end
    rd(8'd0);
    checks++; if (rd_data !== 32'h00010203) begin errors++; $display("FAIL full_rd0 got %h exp 00010203", rd_data); end
  endtask

  task automatic test_clear();
    do_clear();
    for (int i = 0; i < 8; i++) wr(8'hFF, 1'b0);
    checks++; if (byte_count !== 11'd8) begin errors++; $display("FAIL clr_count8 got %0d exp 8", byte_count); end
    clear = 1'b1; in_valid = 1'b1; in_data = 8'h55; rd_req = 1'b1; rd_addr = 8'd0;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL clr_in_ready got %b exp 0", in_ready); end
    tick();
    clear = 1'b0; in_valid = 1'b0; rd_req = 1'b0;
    checks++; if (byte_count !== 11'd0) begin errors++; $display("FAIL clr_count got %0d exp 0", byte_count); end
    checks++; if (rd_valid !== 1'b0 || rd_data !== 32'h00010203) begin errors++; $display("FAIL clr_rd_drop got v=%b %h exp v=0 00010203", rd_valid, rd_data); end
    wr(8'h11, 1'b0);
    checks++; if (byte_count !== 11'd1) begin errors++; $display("FAIL clr_count1 got %0d exp 1", byte_count); end
    rd(8'd0);
    checks++; if (rd_data !== 32'h11000000) begin errors++; $display("FAIL clr_rd0 got %h exp 11000000", rd_data); end
    rd(8'd1);
    checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL clr_rd1 got %h exp 0", rd_data); end
  endtask

  task automatic test_reset_mid();
    do_clear();
    for (int i = 0; i < 37; i++) wr(8'(i + 1), 1'b0);
    rd(8'd0);
    checks++; if (byte_count !== 11'd37 || rd_data !== 32'h01020304) begin errors++; $display("FAIL mid_pre got cnt=%0d %h exp 37 01020304", byte_count, rd_data); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (byte_count !== 11'd0) begin errors++; $display("FAIL mid_count got %0d exp 0", byte_count); end
    checks++; if (blk_avail !== 1'b0 || msg_done !== 1'b0) begin errors++; $display("FAIL mid_flags got blk=%b done=%b exp 0/0", blk_avail, msg_done); end
    checks++; if (rd_valid !== 1'b0 || rd_data !== 32'h0) begin errors++; $display("FAIL mid_rd got v=%b %h exp v=0 0", rd_valid, rd_data); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_in_ready got %b exp 0", in_ready); end
    #2 rst_n = 1'b1;
    test_abc("mid_abc");
    rd(8'd1);
    checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL mid_stale got %h exp 0", rd_data); end
  endtask

  task automatic test_wide();
    for (int i = 1; i <= 9; i++) begin
      w_in_valid = 1'b1; w_in_data = 8'(i); w_in_last = (i == 9);
      tick();
    end
    w_in_valid = 1'b0; w_in_last = 1'b0;
    w_rd_req = 1'b1; w_rd_addr = 4'd1;
    tick();
    w_rd_req = 1'b0;
    checks++; if (w_rd_valid !== 1'b1 || w_rd_data !== 64'h0900000000000000) begin errors++; $display("FAIL wide_rd1 got v=%b %h exp v=1 0900000000000000", w_rd_valid, w_rd_data); end
    w_rd_req = 1'b1; w_rd_addr = 4'd0;
    tick();
    w_rd_req = 1'b0;
    checks++; if (w_rd_data !== 64'h0102030405060708) begin errors++; $display("FAIL wide_rd0 got %h exp 0102030405060708", w_rd_data); end
    checks++; if (w_byte_count !== 8'd9 || w_msg_done !== 1'b1) begin errors++; $display("FAIL wide_state got cnt=%0d done=%b exp 9/1", w_byte_count, w_msg_done); end
  endtask

  initial begin
    clear = 1'b0; in_valid = 1'b0; in_last = 1'b0; rd_req = 1'b0; in_data = 8'h0; rd_addr = 8'h0;
    w_clear = 1'b0; w_in_valid = 1'b0; w_in_last = 1'b0; w_rd_req = 1'b0; w_in_data = 8'h0; w_rd_addr = 4'h0;
    test_reset();
    test_abc("abc");
    test_block();
    test_full();
    test_clear();
    test_reset_mid();
    test_wide();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
